div_sequencer: RTL and testbench

//  Multi-cycle sequencer plus iterative datapath for RV32M DIV/DIVU/REM/REMU in the EX stage.

---
 rtl/rv32im_pkg.sv | 24 ++
 rtl/div_step.sv | 24 ++
 rtl/div_sequencer.sv | 154 +++++++++++++++
 tb/tb_div_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32M divide definitions: ALU opcodes, sequencer state encoding, operand width.
// Pure declarations, no latency; no flow control involved.
// Consumers decide backpressure; nothing here stalls.
package rv32im_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALUOP_DIV  = 5'b01100;
    localparam logic [4:0] ALUOP_DIVU = 5'b01101;
    localparam logic [4:0] ALUOP_REM  = 5'b01110;
    localparam logic [4:0] ALUOP_REMU = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

    // The four divide ops share the 011 prefix; bit 0 = unsigned, bit 1 = remainder.
    function automatic logic is_div_op(input logic [4:0] op);
        return op[4:2] == ALUOP_DIV[4:2];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring divide stage: shift in next dividend bit, trial subtract, retire one quotient bit.
// Latency: purely combinational, chained RADIX_BITS deep per cycle by the sequencer.
// Backpressure: none; the sequencer only advances its registers while BUSY.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // quo_in doubles as the dividend shift register: its MSB feeds the remainder.
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring divide retiring RADIX_BITS quotient bits per cycle.
// Latency: issue cycle + XLEN/RADIX_BITS BUSY cycles, then one FIN cycle with done/result.
// Backpressure: stall holds the pipeline from issue until FIN. Optional macro DIV_FAST_PATH_EN.
module div_sequencer #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            stall
);

    import rv32im_pkg::*;

    localparam int ITER  = XLEN / RADIX_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    div_state_e state, state_next;

    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem_q, quo_q, divisor_q, result_q;
    logic             is_rem_q, neg_quo_q, neg_rem_q;

    logic            accept, fast_case;
    logic            op_signed, sign_a, sign_b, b_zero;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] quo_fin, rem_fin, final_res;

    logic [RADIX_BITS:0][XLEN-1:0] step_rem;
    logic [RADIX_BITS:0][XLEN-1:0] step_quo;

    assign op_signed = ~aluop[0];
    assign sign_a    = op_signed & operand1[XLEN-1];
    assign sign_b    = op_signed & operand2[XLEN-1];
    assign mag_a     = sign_a ? -operand1 : operand1;
    assign mag_b     = sign_b ? -operand2 : operand2;
    assign b_zero    = (operand2 == '0);

    assign accept = start & is_div_op(aluop) & ~flush & (state != ST_BUSY);

`ifdef DIV_FAST_PATH_EN
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    assign div_ovf   = op_signed & (operand1 == {1'b1, {(XLEN-1){1'b0}}}) & (&operand2);
    assign fast_case = b_zero | div_ovf;
    assign fast_res  = b_zero ? (aluop[1] ? operand1 : '1)
                              : (aluop[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`else
    assign fast_case = 1'b0;
`endif

    assign step_rem[0] = rem_q;
    assign step_quo[0] = quo_q;

    for (genvar i = 0; i < RADIX_BITS; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (step_rem[i]),
            .quo_in  (step_quo[i]),
            .divisor (divisor_q),
            .rem_out (step_rem[i+1]),
            .quo_out (step_quo[i+1])
        );
    end

    assign quo_fin = step_quo[RADIX_BITS];
    assign rem_fin = step_rem[RADIX_BITS];

    // Divide by zero leaves quotient all-ones unsigned; remainder sign-fix restores a exactly.
    assign final_res = is_rem_q ? (neg_rem_q ? -rem_fin : rem_fin)
                                : (neg_quo_q ? -quo_fin : quo_fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE, ST_FIN: begin
                if (accept) begin
                    state_next = fast_case ? ST_FIN : ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (count == LAST_CNT) begin
                    state_next = ST_FIN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
        done  = (state == ST_FIN);
        stall = accept | (state == ST_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            // result is only non-zero during the FIN cycle
            result_q <= '0;
            if (accept) begin
                count     <= '0;
                rem_q     <= '0;
                quo_q     <= mag_a;
                divisor_q <= mag_b;
                is_rem_q  <= aluop[1];
                neg_quo_q <= (sign_a ^ sign_b) & ~b_zero;
                neg_rem_q <= sign_a;
`ifdef DIV_FAST_PATH_EN
                if (fast_case) begin
                    result_q <= fast_res;
                end
`endif
            end else if (state == ST_BUSY && !flush) begin
                rem_q <= rem_fin;
                quo_q <= quo_fin;
                count <= count + CNT_W'(1);
                if (count == LAST_CNT) begin
                    result_q <= final_res;
                end
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed vector table plus hand-written flush, back-to-back, reset and random sequences for div_sequencer.
module tb_div_sequencer;
    import rv32im_pkg::*;

    localparam int RB   = 1;
    localparam int W    = 32;
    localparam int ITER = W / RB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          flush;
    logic [4:0]    aluop;
    logic [W-1:0]  operand1;
    logic [W-1:0]  operand2;
    logic [W-1:0]  result;
    logic          done;
    logic          stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(W), .RADIX_BITS(RB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .aluop    (aluop),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .result   (result),
        .done     (done),
        .stall    (stall)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
        sgn = ~op[0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = ITER;
`ifdef DIV_FAST_PATH_EN
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 0;
`else
        if (op == 5'b11111 && a == b && a == 32'd1) lat = ITER;
`endif
        return lat;
    endfunction

    // Counts negedge samples after the issue cycle until done; stall must stay high meanwhile.
    task automatic wait_done(input string name, output int lat, output logic seen, output logic stall_ok);
        lat      = 0;
        seen     = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            lat++;
        end
        check({name, " done seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        int   lat;
        logic seen;
        logic stall_ok;
        @(posedge clk); #1;
        start    = 1'b1;
        aluop    = op;
        operand1 = a;
        operand2 = b;
        @(negedge clk);
        check({name, " issue stall"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start    = 1'b0;
        aluop    = 5'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
        wait_done(name, lat, seen, stall_ok);
        if (seen) begin
            check({name, " result"}, result, exp_res);
            check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
            check({name, " busy stall"}, {31'd0, stall_ok}, 32'd1);
            check({name, " fin stall"}, {31'd0, stall}, 32'd0);
            @(negedge clk);
            check({name, " done pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int   lat;
        int   ndone;
        logic seen;
        logic stall_ok;
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{ALUOP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{ALUOP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{ALUOP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{ALUOP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{ALUOP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[5]  = '{ALUOP_REM,  32'd5,          32'd0,          32'd5};
        vecs[6]  = '{ALUOP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{ALUOP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[8]  = '{ALUOP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{ALUOP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[10] = '{ALUOP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[11] = '{ALUOP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[12] = '{ALUOP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14};
        vecs[13] = '{ALUOP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE};
        vecs[14] = '{ALUOP_DIVU, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF};
        vecs[15] = '{ALUOP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF};
        vecs[16] = '{ALUOP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[17] = '{ALUOP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[18] = '{ALUOP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[19] = '{ALUOP_REMU, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        aluop    = 5'd0;
        operand1 = '0;
        operand2 = '0;
        #12;
        check("reset done",   {31'd0, done},  32'd0);
        check("reset stall",  {31'd0, stall}, 32'd0);
        check("reset result", result,         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Non-divide op must bypass: no stall, no completion.
        @(posedge clk); #1;
        start = 1'b1;
        aluop = 5'b00000;
        @(negedge clk);
        check("bypass stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bypass done", {31'd0, done}, 32'd0);

        // Flush at BUSY count 10.
        @(posedge clk); #1;
        start = 1'b1; aluop = ALUOP_DIVU; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush stall", {31'd0, stall}, 32'd0);
        check("flush done",  {31'd0, done},  32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush no late done", 32'(ndone), 32'd0);
        run_op("after flush", ALUOP_DIVU, 32'd1000, 32'd10, 32'd100);

        // Back-to-back: new op accepted in the FIN cycle of the previous one.
        @(posedge clk); #1;
        start = 1'b1; aluop = ALUOP_DIVU; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b first", lat, seen, stall_ok);
        check("b2b first result", result, 32'd14);
        start = 1'b1; aluop = ALUOP_DIVU; operand1 = 32'd9; operand2 = 32'd3;
        #1;
        check("b2b fin accept stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; operand1 = 32'd77; operand2 = 32'd5;
        wait_done("b2b second", lat, seen, stall_ok);
        check("b2b second result",  result,  32'd3);
        check("b2b second latency", 32'(lat), 32'(ITER));

        // Asynchronous reset mid-BUSY.
        @(posedge clk); #1;
        start = 1'b1; aluop = ALUOP_DIVU; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst stall",  {31'd0, stall}, 32'd0);
        check("arst done",   {31'd0, done},  32'd0);
        check("arst result", result,         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst no done", 32'(ndone), 32'd0);
        run_op("after arst", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = ALUOP_DIV | 5'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), rop, ra, rb, ref_model(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
